pic_bus_master: RTL and testbench
=================================

// Module: pic_bus_master
// PURPOSE
//  CPU-side initiator for the 8259 PIC bus: converts single-beat command requests into
//  8080-style bus cycles on cs_n/rd_n/wr_n/a0/data with programmable setup/strobe/hold.
//  Drives the PIC read/write decode port for ICW/OCW programming and status reads.
//  Sits between the test/host sequencer and the PIC top; one transaction in flight.
// PARAMETERS
//  SETUP_CYC   1  clk cycles cs_n/a0/data valid before strobe falls (>=1)
//  STROBE_CYC  2  clk cycles rd_n or wr_n held low (>=1)
//  HOLD_CYC    1  clk cycles cs_n/a0/data held after strobe rises (>=1; PIC edge detect needs it)
// PORTS
//  clk        in   1  clock
//  rst        in   1  reset, asynchronous, active-low
//  req_valid  in   1  command request
//  req_ready  out  1  block idle, request accepted when valid&ready
//  req_write  in   1  1=write cycle, 0=read cycle
//  req_a0     in   1  address bit A0 for the cycle
//  req_wdata  in   8  write data
//  rsp_valid  out  1  one-cycle pulse: transaction complete
//  rsp_rdata  out  8  read data (valid with rsp_valid on reads; holds last value otherwise)
//  busy       out  1  transaction in progress (~req_ready)
//  cs_n       out  1  chip select, active-low
//  rd_n       out  1  read strobe, active-low
//  wr_n       out  1  write strobe, active-low
//  a0         out  1  address A0
//  dout       out  8  data to PIC
//  dout_oe    out  1  1=drive data bus (write cycles only)
//  din        in   8  data from PIC
// BEHAVIOUR
//  Reset (async): state IDLE; cs_n=rd_n=wr_n=1, a0=0, dout=0x00, dout_oe=0, rsp_valid=0,
//   rsp_rdata=0x00, req_ready=1, busy=0. Reset mid-cycle aborts; no rsp_valid issued.
//  All bus outputs are flops updated with the state register; no combinational glitches.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. Down-counter loaded on each entry.
//   IDLE: req_ready=1; on req_valid latch write/a0/wdata, go SETUP.
//   SETUP: cs_n=0, a0=latched, dout=wdata, dout_oe=write; rd_n=wr_n=1; SETUP_CYC cycles.
//   STROBE: wr_n=0 (write) or rd_n=0 (read); others as SETUP; STROBE_CYC cycles.
//    Read: rsp_rdata <= din on the clk edge that leaves STROBE.
//   HOLD: strobe back to 1; cs_n, a0, dout, dout_oe unchanged; HOLD_CYC cycles.
//   HOLD exit: cs_n=1, dout_oe=0, rsp_valid=1 for exactly one cycle, re-enter IDLE.
//  Latency defaults: accept edge T -> cs_n low T+1..T+4, strobe low T+2..T+3, rsp T+5.
//  General: cycle length = SETUP_CYC+STROBE_CYC+HOLD_CYC, rsp one cycle later.
//  Back-to-back: next accept at earliest in the rsp_valid cycle, so cs_n high >=1 cycle
//   between transactions (rearms the PIC write edge detector).
//  req_valid while busy: ignored; request fields not sampled; no queueing.
//  req_* changes after accept: no effect (latched).
//  Counter width $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1); loads PARAM-1, exits at 0.
// STRUCTURE
//  pic_pkg: bus_state_t enum {IDLE,SETUP,STROBE,HOLD}; command bit constants
//   ICW1_SEL_BIT=4, OCW3_SEL_BIT=3, ICW1_IC4=0 for sequencer/bench use.
//  Sub-module pic_bus_timer: loadable down-counter with zero flag; FSM in top.
// TESTING (bench includes PIC read/write decode as responder)
//  Write a0=0 wdata=0x13 defaults -> cs_n low T+1..T+4, wr_n low T+2..T+3, dout=0x13,
//   dout_oe=1, rsp_valid at T+5; PIC writeICW1 pulses exactly once.
//  Write a0=1 wdata=0x08 -> PIC internal data bus 0x08, writeICW2to4 single pulse, rd_n stays 1.
//  Read a0=0 with din=0xA5 during strobe -> rsp_rdata=0xA5 with rsp_valid, dout_oe=0 throughout.
//  Two writes back-to-back (req_valid held) -> cs_n high exactly 1 cycle between, 2 rsp pulses.
//  rst low during STROBE -> all outputs at reset values immediately, no rsp_valid, next req OK.
//  STROBE_CYC=4, HOLD_CYC=2 -> wr_n low 4 cycles, rsp at T+8; req_valid while busy ignored.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: shared state encoding and 8259 command-byte field positions for the PIC bus master.
package pic_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} bus_state_t;
    localparam int ICW1_SEL_BIT = 4;
    localparam int OCW3_SEL_BIT = 3;
    localparam int ICW1_IC4     = 0;
endpackage

// File: rtl/pic_bus_timer.sv
// pic_bus_timer: loadable down-counter that stops at zero and flags it.
module pic_bus_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (load) count <= load_val;
        else if (count != '0) count <= count - 1'b1;
    assign zero = count == '0;
endmodule

// File: rtl/pic_bus_master.sv
// pic_bus_master: turns single-beat requests into 8080-style cs_n/rd_n/wr_n cycles for the 8259.
// Every bus output is a flop written alongside the state register, so the pins never glitch.
module pic_bus_master
    import pic_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_a0,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a0,
    output logic [7:0] dout,
    output logic       dout_oe,
    input  logic [7:0] din
);
    localparam int MAXC = SETUP_CYC > STROBE_CYC ? (SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC)
                                                 : (STROBE_CYC > HOLD_CYC ? STROBE_CYC : HOLD_CYC);
    localparam int CW = $clog2(MAXC + 1);

    bus_state_t state, state_n;
    logic write_q, write_n, cs_n_n, rd_n_n, wr_n_n, a0_n, dout_oe_n, rsp_valid_n;
    logic [7:0] dout_n, rdata_n;
    logic load, zero;
    logic [CW-1:0] load_val;

    pic_bus_timer #(.W(CW)) u_timer (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .zero(zero)
    );

    always_comb begin
        state_n     = state;
        write_n     = write_q;
        cs_n_n      = cs_n;
        rd_n_n      = rd_n;
        wr_n_n      = wr_n;
        a0_n        = a0;
        dout_n      = dout;
        dout_oe_n   = dout_oe;
        rsp_valid_n = 1'b0;
        rdata_n     = rsp_rdata;
        load        = 1'b0;
        load_val    = '0;
        case (state)
            IDLE: if (req_valid) begin
                state_n   = SETUP;
                write_n   = req_write;
                a0_n      = req_a0;
                dout_n    = req_wdata;
                dout_oe_n = req_write;
                cs_n_n    = 1'b0;
                load      = 1'b1;
                load_val  = CW'(SETUP_CYC - 1);
            end
            SETUP: if (zero) begin
                state_n  = STROBE;
                wr_n_n   = !write_q;
                rd_n_n   = write_q;
                load     = 1'b1;
                load_val = CW'(STROBE_CYC - 1);
            end
            STROBE: if (zero) begin
                state_n  = HOLD;
                wr_n_n   = 1'b1;
                rd_n_n   = 1'b1;
                rdata_n  = write_q ? rsp_rdata : din;
                load     = 1'b1;
                load_val = CW'(HOLD_CYC - 1);
            end
            HOLD: if (zero) begin
                state_n     = IDLE;
                cs_n_n      = 1'b1;
                dout_oe_n   = 1'b0;
                rsp_valid_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            cs_n      <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            a0        <= 1'b0;
            dout      <= 8'h00;
            dout_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= state_n;
            write_q   <= write_n;
            cs_n      <= cs_n_n;
            rd_n      <= rd_n_n;
            wr_n      <= wr_n_n;
            a0        <= a0_n;
            dout      <= dout_n;
            dout_oe   <= dout_oe_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rdata_n;
        end

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_pic_bus_master.sv
// tb_pic_bus_master: directed vectors against the default master, with an 8259-style write
// decoder as responder, plus a second master using a longer strobe and hold.
module tb_pic_bus_master;
    import pic_pkg::*;

    logic clk = 1'b0, rst = 1'b0;
    logic req_valid = 1'b0, req_valid2 = 1'b0, req_write = 1'b0, req_a0 = 1'b0;
    logic [7:0] req_wdata = 8'h00, din = 8'h00;
    logic req_ready, rsp_valid, busy, cs_n, rd_n, wr_n, a0, dout_oe;
    logic [7:0] rsp_rdata, dout;
    logic req_ready2, rsp_valid2, busy2, cs_n2, rd_n2, wr_n2, a02, dout_oe2;
    logic [7:0] rsp_rdata2, dout2;

    always #5 clk = ~clk;

    pic_bus_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_a0(req_a0), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0), .dout(dout), .dout_oe(dout_oe), .din(din)
    );

    pic_bus_master #(.SETUP_CYC(1), .STROBE_CYC(4), .HOLD_CYC(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write), .req_a0(req_a0), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
        .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2), .a0(a02), .dout(dout2), .dout_oe(dout_oe2), .din(din)
    );

    // PIC-side write decode: one pulse per falling wr_n while selected
    logic wr_prev = 1'b1;
    logic [7:0] pic_bus = 8'h00;
    int icw1_cnt = 0, icw24_cnt = 0, ocw3_cnt = 0;
    always @(posedge clk) begin
        wr_prev <= wr_n;
        if (wr_prev && !wr_n && !cs_n) begin
            pic_bus <= dout;
            if (a0) icw24_cnt <= icw24_cnt + 1;
            else if (dout[ICW1_SEL_BIT]) icw1_cnt <= icw1_cnt + 1;
            else if (dout[OCW3_SEL_BIT]) ocw3_cnt <= ocw3_cnt + 1;
        end
    end

    typedef struct {
        logic       write;
        logic       a0;
        logic [7:0] wdata;
        logic [7:0] din;
        logic [7:0] exp_rdata;
        int         d_icw1;
        int         d_icw24;
        int         d_ocw3;
        logic [7:0] exp_bus;
    } vec_t;

    vec_t vecs[5];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, output int lat, output int cs_cnt, output int st_cnt,
                          output int oth_cnt, output int oe_bad, output int dout_bad,
                          output logic [7:0] rdata);
        lat = 0; cs_cnt = 0; st_cnt = 0; oth_cnt = 0; oe_bad = 0; dout_bad = 0; rdata = 8'hxx;
        @(negedge clk);
        req_valid = 1'b1; req_write = v.write; req_a0 = v.a0; req_wdata = v.wdata; din = v.din;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0; req_write = ~v.write; req_a0 = ~v.a0; req_wdata = ~v.wdata;
            end
            cs_cnt  += int'(!cs_n);
            st_cnt  += int'(v.write ? !wr_n : !rd_n);
            oth_cnt += int'(v.write ? !rd_n : !wr_n);
            if (!cs_n && dout_oe !== v.write) oe_bad++;
            if (v.write && !cs_n && dout !== v.wdata) dout_bad++;
            if (rsp_valid) begin lat = k; rdata = rsp_rdata; end
        end
    endtask

    initial begin
        int lat, cs_cnt, st_cnt, oth_cnt, oe_bad, dout_bad, i1, i24, o3;
        int rsp_cnt, runs, gap, acc, wr_cnt, rd_cnt;
        logic prev_cs, found;
        logic [7:0] rdata;
        vecs[0] = '{1'b1, 1'b0, 8'h13, 8'h00, 8'h00, 1, 0, 0, 8'h13};
        vecs[1] = '{1'b1, 1'b1, 8'h08, 8'h00, 8'h00, 0, 1, 0, 8'h08};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 8'hA5, 8'hA5, 0, 0, 0, 8'h08};
        vecs[3] = '{1'b1, 1'b0, 8'h0B, 8'h00, 8'hA5, 0, 0, 1, 8'h0B};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h3C, 8'h3C, 0, 0, 0, 8'h0B};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {cs_n, rd_n, wr_n, a0, dout, dout_oe, rsp_valid, rsp_rdata, req_ready, busy},
            {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        rst = 1'b1;

        for (int v = 0; v < 5; v++) begin
            i1 = icw1_cnt; i24 = icw24_cnt; o3 = ocw3_cnt;
            do_txn(vecs[v], lat, cs_cnt, st_cnt, oth_cnt, oe_bad, dout_bad, rdata);
            chk($sformatf("v%0d_latency", v), lat, 5);
            chk($sformatf("v%0d_cs_low", v), cs_cnt, 4);
            chk($sformatf("v%0d_strobe_low", v), st_cnt, 2);
            chk($sformatf("v%0d_other_strobe", v), oth_cnt, 0);
            chk($sformatf("v%0d_dout_oe", v), oe_bad, 0);
            chk($sformatf("v%0d_dout", v), dout_bad, 0);
            chk($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
            chk($sformatf("v%0d_icw1", v), icw1_cnt - i1, vecs[v].d_icw1);
            chk($sformatf("v%0d_icw24", v), icw24_cnt - i24, vecs[v].d_icw24);
            chk($sformatf("v%0d_ocw3", v), ocw3_cnt - o3, vecs[v].d_ocw3);
            chk($sformatf("v%0d_pic_bus", v), pic_bus, vecs[v].exp_bus);
        end

        // back-to-back writes with req_valid held high
        @(negedge clk);
        i24 = icw24_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_a0 = 1'b1; req_wdata = 8'h55;
        acc = 1; rsp_cnt = 0; runs = 0; gap = 0; prev_cs = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (!cs_n && prev_cs) runs++;
            if (cs_n && runs == 1) gap++;
            prev_cs = cs_n;
            rsp_cnt += int'(rsp_valid);
            if (acc == 2) req_valid = 1'b0;
            else if (req_ready) acc++;
        end
        chk("b2b_accepts", acc, 2);
        chk("b2b_rsp_pulses", rsp_cnt, 2);
        chk("b2b_cs_gap", gap, 1);
        chk("b2b_cs_runs", runs, 2);
        chk("b2b_icw24", icw24_cnt - i24, 2);
        chk("b2b_pic_bus", pic_bus, 8'h55);

        // asynchronous reset during the strobe phase
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_a0 = 1'b0; req_wdata = 8'h13;
        found = 1'b0;
        for (int k = 1; k <= 10 && !found; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            found = !wr_n;
        end
        chk("rst_reach_strobe", found, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs", {cs_n, rd_n, wr_n, a0, dout, dout_oe, rsp_valid, rsp_rdata, req_ready, busy},
            {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        rsp_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b1;
            rsp_cnt += int'(rsp_valid);
        end
        chk("rst_no_rsp", rsp_cnt, 0);
        do_txn(vecs[2], lat, cs_cnt, st_cnt, oth_cnt, oe_bad, dout_bad, rdata);
        chk("post_rst_latency", lat, 5);
        chk("post_rst_rdata", rdata, 8'hA5);

        // longer strobe/hold; a request arriving while busy must be ignored
        @(negedge clk);
        req_valid2 = 1'b1; req_write = 1'b1; req_a0 = 1'b1; req_wdata = 8'h77;
        lat = 0; cs_cnt = 0; wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0; dout_bad = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin req_write = 1'b0; req_a0 = 1'b0; req_wdata = 8'hFF; end
            if (k == 6) req_valid2 = 1'b0;
            cs_cnt += int'(!cs_n2);
            wr_cnt += int'(!wr_n2);
            rd_cnt += int'(!rd_n2);
            if (!cs_n2 && (dout2 !== 8'h77 || a02 !== 1'b1 || dout_oe2 !== 1'b1)) dout_bad++;
            if (rsp_valid2) begin rsp_cnt++; if (lat == 0) lat = k; end
        end
        chk("long_latency", lat, 8);
        chk("long_cs_low", cs_cnt, 7);
        chk("long_wr_low", wr_cnt, 4);
        chk("long_rd_low", rd_cnt, 0);
        chk("long_latched_fields", dout_bad, 0);
        chk("long_busy_ignored", rsp_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
